// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and physical memory line interfaces seen by cache_arbiter.
// The slave modport is the arbiter's view; master is the view of the caches and memory around it.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I-cache fills and D-cache fills/write-backs onto one line memory port.
//   state   | meaning
//   IDLE    | no transaction; arbitrate pending requests
//   SERVE_I | latched I-cache read in flight, waiting for mem_resp
//   SERVE_D | latched D-cache read or write in flight, waiting for mem_resp
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input logic           clk,
    input logic           rst_n,
    cache_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_grant;
    logic                  cmd_read;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LINE_WIDTH-1:0] cmd_wdata;

    logic                  i_req;
    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // Tie goes to the client that was not granted last time (last_grant: 0=I, 1=D).
    assign grant_i = (state == IDLE) && i_req && (!d_req || last_grant);
    assign grant_d = (state == IDLE) && d_req && !grant_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_read   <= 1'b0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i) begin
                last_grant <= 1'b0;
                cmd_read   <= 1'b1;
                cmd_write  <= 1'b0;
                cmd_addr   <= bus.i_address;
                cmd_wdata  <= '0;
            end else if (grant_d) begin
                last_grant <= 1'b1;
                cmd_read   <= !bus.d_write;
                cmd_write  <= bus.d_write;
                cmd_addr   <= bus.d_address;
                cmd_wdata  <= bus.d_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = SERVE_I;
                end else if (grant_d) begin
                    state_nxt = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory side is driven only from the latched command, never from live client inputs.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = cmd_addr;
        bus.mem_wdata   = cmd_wdata;
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        case (state)
            SERVE_I: begin
                bus.mem_read  = cmd_read;
                bus.mem_write = cmd_write;
                bus.i_resp    = rst_n && bus.mem_resp;
            end
            SERVE_D: begin
                bus.mem_read  = cmd_read;
                bus.mem_write = cmd_write;
                bus.d_resp    = rst_n && bus.mem_resp;
            end
            default: begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        endcase
    end

    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Two-client line-memory arbiter between the L1 instruction cache, the L1 data cache and the physical memory port of the LC-3b processor top.
- Serialises I-cache line fills and D-cache fills/write-backs onto the single 128-bit read/write/resp memory interface.
- Uses round-robin grant.
- Latches the granted command for the whole memory transaction.

Parameters:
- ADDR_WIDTH, 16, byte address width on all ports.
- LINE_WIDTH, 128, cache line / memory data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line data to I-cache
- i_resp  out  1  I-cache completion pulse
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line write request; held until d_resp
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache write-back line
- d_rdata  out  LINE_WIDTH  line data to D-cache
- d_resp  out  1  D-cache completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data
- mem_resp  in  1  memory completion, one cycle per transaction

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D. Register last_grant (0=I, 1=D).
- Reset (rst_n low at posedge):
  - state=IDLE, last_grant=1, so I wins the first tie.
  - Latched cmd, address and wdata are cleared to 0.
- Outputs after reset: mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, i_resp=0, d_resp=0.
- D request is d_read|d_write. If both are high, the request is a write (d_write wins).
- IDLE:
  - Only I request: go SERVE_I; latch read, i_address.
  - Only D request: go SERVE_D; latch read/write, d_address, d_wdata.
  - Both: grant the client not equal to last_grant.
  - On grant, last_grant updates to the granted client.
  - No request: stay.
- SERVE_x:
  - mem_read/mem_write, mem_address and mem_wdata are driven from latched registers only. Client inputs are not passed through.
  - Strobes stay high until mem_resp.
- Completion:
  - When mem_resp=1 in SERVE_x, x_resp=1 in the same cycle (combinational from mem_resp & state).
  - Next state is IDLE.
  - The non-served client's resp stays 0.
- i_rdata and d_rdata are wired to mem_rdata permanently. Validity is only guaranteed while the respective resp=1.
- Latency:
  - Request seen at edge N: mem strobe high from cycle N+1.
  - Client resp coincides with mem_resp.
  - One IDLE cycle after every completion, so the memory strobe drops for at least one cycle between transactions.
- Clients drop requests the cycle after resp. A request still high in IDLE is treated as a new request.
- Request withdrawn mid-transaction: ignored; the transaction completes and resp is still pulsed.
- Client address/data changing mid-transaction: no effect (latched).
- mem_resp in IDLE: ignored; no client resp.
- Reset mid-transaction: next state IDLE, strobes 0 the next cycle, no client resp; a later mem_resp is ignored.
- Never both mem_read and mem_write high. Never both i_resp and d_resp high.

Test Plan:
- I read only:
  - Stimulus: i_read=1, i_address=0x1230; memory returns 0xAAAA...AAAA after 3 cycles.
  - Response: mem_read=1 with mem_address=0x1230 from cycle 1; i_resp=1 with i_rdata=0xAAAA...; mem_read=0 the next cycle; d_resp never 1.
- D write only:
  - Stimulus: d_write=1, d_address=0x4010, d_wdata=0x0123...CDEF.
  - Response: mem_write=1 with mem_address=0x4010 and wdata 0x0123...CDEF; mem_read stays 0; d_resp with mem_resp.
- Round-robin:
  - Stimulus: i_read and d_read asserted together after reset and re-asserted after each resp.
  - Response: grant order I, D, I, D over 4 transactions.
- Latching:
  - Stimulus: after grant, change d_address 0x4010→0x7FF0 and drop d_write.
  - Response: mem_address stays 0x4010 and mem_write stays high until mem_resp; d_resp still pulses.
- Reset mid-transaction:
  - Stimulus: rst_n=0 during SERVE_D, then mem_resp=1.
  - Response: strobes 0 the next cycle; no d_resp; arbiter idles.
- Spurious mem_resp in IDLE:
  - Stimulus: mem_resp=1 with no requests.
  - Response: i_resp=d_resp=0; state stays IDLE.
